branch_unit: RTL and testbench
==============================

// Module: branch_unit
// PURPOSE
//   Registered, parametrised branch resolution unit for the bitty core.
//   Captures the last ALU compare result as a 2-bit condition code, evaluates
//   branch instructions (opcode 2'b10) against it, and emits a one-cycle
//   pc_load pulse with the next PC. Sits between decode/ALU and the PC register.
// PARAMETERS
//   ADDR_W     8   PC / branch-target width; requires INSTR_W >= ADDR_W+6
//   DATA_W     16  ALU result width
//   INSTR_W    16  instruction width
//   RAS_DEPTH  4   return-address-stack entries (BRANCH_RAS_EN only), >= 2
// PORTS
//   clk          in   1        clock, all state on rising edge
//   reset        in   1        synchronous, active-high
//   instr_valid  in   1        instruction is valid this cycle
//   instruction  in   INSTR_W  [1:0] opcode, [3:2] cond, [ADDR_W+3:4] target,
//                              [ADDR_W+4] call, [ADDR_W+5] ret
//   pc_in        in   ADDR_W   PC of the presented instruction
//   alu_valid    in   1        alu_result is a new compare result
//   alu_result   in   DATA_W   ALU result
//   new_pc       out  ADDR_W   next PC for evaluated branch
//   pc_load      out  1        1-cycle pulse: PC must load new_pc
//   br_valid     out  1        1-cycle pulse: a branch was evaluated
//   ras_err      out  1        1-cycle pulse: RAS underflow (0 without macro)
// BEHAVIOUR
//   - Reset (priority over all inputs): cc=2'b11, new_pc=0, pc_load=0,
//     br_valid=0, ras_err=0, RAS count=0, RAS pointer=0.
//   - cc update on alu_valid: result==0 -> 0, ==1 -> 1, ==2 -> 2, else -> 3.
//   - Forwarding: alu_valid with instr_valid same cycle -> branch evaluates the
//     incoming code, not stale cc; cc still updates.
//   - Branch = instr_valid && opcode==2'b10. Conditions: cond 0/1/2 taken iff
//     code==cond; cond 3 always taken. cc==3 never satisfies cond 0..2.
//   - Latency 1: outputs registered at the edge after the branch cycle.
//     Taken: pc_load=1, new_pc=target. Not taken: pc_load=0, new_pc=pc_in+1
//     (mod 2^ADDR_W, 255+1 -> 0). br_valid=1 in both cases.
//   - Non-branch or instr_valid=0: pc_load=0, br_valid=0, new_pc holds.
//   - Back-to-back branches each produce their own pulse; no stall, no bubble.
//   - target zero-extended/truncated to ADDR_W exactly as bits [ADDR_W+3:4].
// CONFIGURATION
//   BRANCH_RAS_EN defined: circular return-address stack, RAS_DEPTH entries.
//   - cond 3 + call=1: push pc_in+1, jump to target.
//   - cond 3 + ret=1 (call=0): pop, new_pc=popped, pc_load=1.
//   - Push when full: overwrite oldest, count saturates at RAS_DEPTH.
//   - Pop when empty: not taken, new_pc=pc_in+1, pc_load=0, ras_err=1.
//   - call=1 and ret=1 together: treated as call.
//   - call/ret bits ignored for cond 0..2.
//   BRANCH_RAS_EN undefined: no stack storage; call/ret bits ignored; cond 3
//   is a plain unconditional jump; ras_err tied 0.
// TESTING
//   1 reset, then BEQ target 0x40 with no ALU result -> not taken,
//     new_pc=pc_in+1, br_valid=1, pc_load=0.
//   2 alu_result=0, next cycle BEQ target 0x40, pc_in=0x10 -> next cycle
//     pc_load=1, new_pc=0x40; repeat with alu_result=5 -> new_pc=0x11, pc_load=0.
//   3 same cycle alu_valid, alu_result=2 and BLT (cond 2) target 0x22 ->
//     taken via forwarding, new_pc=0x22.
//   4 not-taken BGT at pc_in=0xFF -> new_pc=0x00; non-branch opcode 2'b01
//     -> no pulses, new_pc unchanged.
//   5 (RAS_EN) 5 nested calls, DEPTH=4, from pc 0x01..0x05, then 5 rets ->
//     returns 0x06,0x05,0x04,0x03, 5th ret ras_err=1, pc_load=0.
//   6 reset asserted in the cycle after a taken branch is presented -> all
//     outputs 0 next edge, RAS emptied, cc=3.

Source files
------------

// File: rtl/branch_unit.sv
// Registered branch resolution unit: condition-code capture, branch evaluation, next-PC pulse.
// Optional return-address stack enabled by defining BRANCH_RAS_EN.
module branch_unit #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int INSTR_W   = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               alu_valid,
  input  logic [DATA_W-1:0]  alu_result,
  output logic [ADDR_W-1:0]  new_pc,
  output logic               pc_load,
  output logic               br_valid,
  output logic               ras_err
);

  logic [1:0]        cc_reg;
  logic [1:0]        alu_code;
  logic [1:0]        code;
  logic [1:0]        opcode;
  logic [1:0]        cond;
  logic [ADDR_W-1:0] target;
  logic              call_bit;
  logic              ret_bit;
  logic              is_branch;
  logic [ADDR_W-1:0] pc_next;
  logic              taken_next;
  logic [ADDR_W-1:0] dest_next;
  logic              err_next;
  logic              unused_instr;

  assign opcode       = instruction[1:0];
  assign cond         = instruction[3:2];
  assign target       = instruction[ADDR_W+3:4];
  assign call_bit     = instruction[ADDR_W+4];
  assign ret_bit      = instruction[ADDR_W+5];
  assign unused_instr = ^instruction;

  assign is_branch = instr_valid && (opcode == 2'b10);
  assign pc_next   = pc_in + ADDR_W'(1);

  always_comb begin
    alu_code = 2'd3;
    if (alu_result == DATA_W'(0))      alu_code = 2'd0;
    else if (alu_result == DATA_W'(1)) alu_code = 2'd1;
    else if (alu_result == DATA_W'(2)) alu_code = 2'd2;
  end

  // Same-cycle compare result wins over the stored code.
  assign code = alu_valid ? alu_code : cc_reg;

`ifdef BRANCH_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_reg;
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;
  logic [CNT_W-1:0]  count_reg;
  logic              do_push;
  logic              do_pop;
  logic              ras_empty;
  logic              ras_err_reg;

  assign do_push   = is_branch && (cond == 2'd3) && call_bit;
  assign do_pop    = is_branch && (cond == 2'd3) && !call_bit && ret_bit;
  assign ras_empty = (count_reg == '0);
  assign ptr_inc   = (ptr_reg == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_reg + PTR_W'(1);
  assign ptr_dec   = (ptr_reg == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_reg - PTR_W'(1);

  // ptr_reg is the next write slot; a full push overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (!reset && do_push) ras_mem[ptr_reg] <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg     <= '0;
      count_reg   <= '0;
      ras_err_reg <= 1'b0;
    end else begin
      ras_err_reg <= err_next;
      if (do_push) begin
        ptr_reg <= ptr_inc;
        if (count_reg != CNT_W'(RAS_DEPTH)) count_reg <= count_reg + CNT_W'(1);
      end else if (do_pop && !ras_empty) begin
        ptr_reg   <= ptr_dec;
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  assign ras_err = ras_err_reg;

  always_comb begin
    taken_next = (cond == 2'd3) || (code == cond);
    dest_next  = target;
    err_next   = 1'b0;
    if (do_pop) begin
      if (ras_empty) begin
        taken_next = 1'b0;
        err_next   = is_branch;
      end else begin
        dest_next = ras_mem[ptr_dec];
      end
    end
  end
`else
  assign ras_err = 1'b0;

  always_comb begin
    taken_next = (cond == 2'd3) || (code == cond);
    dest_next  = target;
    err_next   = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cc_reg   <= 2'd3;
      new_pc   <= '0;
      pc_load  <= 1'b0;
      br_valid <= 1'b0;
    end else begin
      if (alu_valid) cc_reg <= alu_code;
      pc_load  <= is_branch && taken_next;
      br_valid <= is_branch;
      if (is_branch) new_pc <= taken_next ? dest_next : pc_next;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_branch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instruction = '0;
  logic [7:0]  pc_in = '0;
  logic        alu_valid = 1'b0;
  logic [15:0] alu_result = '0;
  logic [7:0]  new_pc;
  logic        pc_load;
  logic        br_valid;
  logic        ras_err;

  int n_pass = 0;
  int n_total = 0;
  logic [10:0] obs;
  logic [10:0] expv;

  // reference model state
  logic [1:0] m_cc;
  logic [7:0] m_ras[$];
  logic [7:0] e_new_pc;
  bit         e_pc_load, e_br, e_err;

  typedef struct {
    bit          rst;
    bit          iv;
    logic [15:0] ins;
    logic [7:0]  pc;
    bit          av;
    logic [15:0] ar;
    logic [10:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  branch_unit #(.ADDR_W(8), .DATA_W(16), .INSTR_W(16), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .pc_in(pc_in), .alu_valid(alu_valid), .alu_result(alu_result),
    .new_pc(new_pc), .pc_load(pc_load), .br_valid(br_valid), .ras_err(ras_err)
  );

  function automatic logic [15:0] mk(input logic [1:0] op, input logic [1:0] cnd,
                                     input logic [7:0] tgt, input bit call, input bit ret);
    logic [15:0] w;
    w = '0;
    w[1:0] = op; w[3:2] = cnd; w[11:4] = tgt; w[12] = call; w[13] = ret;
    return w;
  endfunction

  function automatic logic [10:0] ev(input bit b, input bit l, input bit e, input logic [7:0] p);
    return {b, l, e, p};
  endfunction

  // Behavioural model: outputs of the edge that follows this cycle's inputs.
  task automatic model(input bit rst, input bit iv, input logic [15:0] ins, input logic [7:0] pc,
                       input bit av, input logic [15:0] ar);
    logic [1:0] c, cnd;
    logic [7:0] dest;
    bit taken;
    if (rst) begin
      m_cc = 2'd3; m_ras.delete();
      e_new_pc = 8'h00; e_pc_load = 0; e_br = 0; e_err = 0;
      return;
    end
    c = av ? ((ar < 16'd3) ? ar[1:0] : 2'd3) : m_cc;
    if (av) m_cc = c;
    e_br = 0; e_pc_load = 0; e_err = 0;
    if (iv && ins[1:0] == 2'b10) begin
      cnd = ins[3:2];
      dest = ins[11:4];
      taken = (cnd == 2'd3) || (cnd == c);
`ifdef BRANCH_RAS_EN
      if (cnd == 2'd3 && ins[12]) begin
        m_ras.push_back(pc + 8'd1);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end else if (cnd == 2'd3 && ins[13]) begin
        if (m_ras.size() == 0) begin taken = 0; e_err = 1; end
        else dest = m_ras.pop_back();
      end
`endif
      e_br = 1;
      e_pc_load = taken;
      e_new_pc = taken ? dest : pc + 8'd1;
    end
  endtask

  task automatic step(input bit rst, input bit iv, input logic [15:0] ins, input logic [7:0] pc,
                      input bit av, input logic [15:0] ar);
    reset = rst; instr_valid = iv; instruction = ins; pc_in = pc;
    alu_valid = av; alu_result = ar;
    model(rst, iv, ins, pc, av, ar);
    @(posedge clk); #1;
    obs = {br_valid, pc_load, ras_err, new_pc};
    $display("txn rst=%0b iv=%0b ins=%h pc=%h av=%0b ar=%h -> br=%0b ld=%0b err=%0b new_pc=%h",
             rst, iv, ins, pc, av, ar, br_valid, pc_load, ras_err, new_pc);
  endtask

  task automatic test_reset();
    vec_t v[$];
    v.push_back('{1, 0, 16'h0, 8'h00, 0, 16'h0, ev(0,0,0,8'h00)});
    v.push_back('{1, 1, mk(2,3,8'h55,0,0), 8'h01, 1, 16'h0, ev(0,0,0,8'h00)});
    v.push_back('{0, 1, mk(2,0,8'h40,0,0), 8'h10, 0, 16'h0, ev(1,0,0,8'h11)});
    foreach (v[i]) begin
      step(v[i].rst, v[i].iv, v[i].ins, v[i].pc, v[i].av, v[i].ar);
      n_total++;
      if (obs !== v[i].exp) $display("FAIL reset[%0d]: got {br,ld,err,pc}=%h want %h", i, obs, v[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_cc_update();
    vec_t v[$];
    v.push_back('{0, 0, 16'h0, 8'h00, 1, 16'd0, ev(0,0,0,8'h11)});
    v.push_back('{0, 1, mk(2,0,8'h40,0,0), 8'h10, 0, 16'h0, ev(1,1,0,8'h40)});
    v.push_back('{0, 0, 16'h0, 8'h00, 1, 16'd5, ev(0,0,0,8'h40)});
    v.push_back('{0, 1, mk(2,0,8'h40,0,0), 8'h10, 0, 16'h0, ev(1,0,0,8'h11)});
    v.push_back('{0, 0, 16'h0, 8'h00, 1, 16'd1, ev(0,0,0,8'h11)});
    v.push_back('{0, 1, mk(2,1,8'h21,0,0), 8'h20, 0, 16'h0, ev(1,1,0,8'h21)});
    v.push_back('{0, 1, mk(2,2,8'h30,0,0), 8'h20, 0, 16'h0, ev(1,0,0,8'h21)});
    foreach (v[i]) begin
      step(v[i].rst, v[i].iv, v[i].ins, v[i].pc, v[i].av, v[i].ar);
      n_total++;
      if (obs !== v[i].exp) $display("FAIL cc_update[%0d]: got {br,ld,err,pc}=%h want %h", i, obs, v[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_forwarding();
    vec_t v[$];
    v.push_back('{0, 1, mk(2,2,8'h22,0,0), 8'h50, 1, 16'd2, ev(1,1,0,8'h22)});
    v.push_back('{0, 1, mk(2,2,8'h33,0,0), 8'h51, 0, 16'h0, ev(1,1,0,8'h33)});
    v.push_back('{0, 1, mk(2,2,8'h44,0,0), 8'h52, 1, 16'hFFFF, ev(1,0,0,8'h53)});
    v.push_back('{0, 1, mk(2,0,8'h44,0,0), 8'h60, 1, 16'd0, ev(1,1,0,8'h44)});
    foreach (v[i]) begin
      step(v[i].rst, v[i].iv, v[i].ins, v[i].pc, v[i].av, v[i].ar);
      n_total++;
      if (obs !== v[i].exp) $display("FAIL forwarding[%0d]: got {br,ld,err,pc}=%h want %h", i, obs, v[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_and_nonbranch();
    vec_t v[$];
    v.push_back('{0, 1, mk(2,1,8'h10,0,0), 8'hFF, 0, 16'h0, ev(1,0,0,8'h00)});
    v.push_back('{0, 1, mk(1,3,8'h77,0,0), 8'h20, 0, 16'h0, ev(0,0,0,8'h00)});
    v.push_back('{0, 0, mk(2,3,8'h77,0,0), 8'h20, 0, 16'h0, ev(0,0,0,8'h00)});
    v.push_back('{0, 1, mk(3,0,8'h77,0,0), 8'h20, 0, 16'h0, ev(0,0,0,8'h00)});
    foreach (v[i]) begin
      step(v[i].rst, v[i].iv, v[i].ins, v[i].pc, v[i].av, v[i].ar);
      n_total++;
      if (obs !== v[i].exp) $display("FAIL wrap_nonbranch[%0d]: got {br,ld,err,pc}=%h want %h", i, obs, v[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    v.push_back('{0, 1, mk(2,3,8'h12,0,0), 8'h01, 0, 16'h0, ev(1,1,0,8'h12)});
    v.push_back('{0, 1, mk(2,0,8'h13,0,0), 8'h02, 0, 16'h0, ev(1,1,0,8'h13)});
    v.push_back('{0, 1, mk(2,1,8'h14,0,0), 8'h03, 0, 16'h0, ev(1,0,0,8'h04)});
    v.push_back('{0, 1, mk(2,3,8'hFE,0,0), 8'h04, 0, 16'h0, ev(1,1,0,8'hFE)});
    v.push_back('{0, 1, mk(2,2,8'h15,0,0), 8'hFE, 1, 16'd2, ev(1,1,0,8'h15)});
    foreach (v[i]) begin
      step(v[i].rst, v[i].iv, v[i].ins, v[i].pc, v[i].av, v[i].ar);
      n_total++;
      if (obs !== v[i].exp) $display("FAIL back_to_back[%0d]: got {br,ld,err,pc}=%h want %h", i, obs, v[i].exp);
      else n_pass++;
    end
  endtask

`ifdef BRANCH_RAS_EN
  task automatic test_ras();
    vec_t v[$];
    v.push_back('{1, 0, 16'h0, 8'h00, 0, 16'h0, ev(0,0,0,8'h00)});
    for (int i = 1; i <= 5; i++)
      v.push_back('{0, 1, mk(2,3,8'h80 + 8'(i),1,0), 8'(i), 0, 16'h0, ev(1,1,0,8'h80 + 8'(i))});
    for (int j = 0; j < 4; j++)
      v.push_back('{0, 1, mk(2,3,8'h7F,0,1), 8'h30 + 8'(j), 0, 16'h0, ev(1,1,0,8'h06 - 8'(j))});
    v.push_back('{0, 1, mk(2,3,8'h7F,0,1), 8'h34, 0, 16'h0, ev(1,0,1,8'h35)});
    v.push_back('{0, 1, mk(2,3,8'h90,1,1), 8'h40, 0, 16'h0, ev(1,1,0,8'h90)});
    v.push_back('{0, 1, mk(2,0,8'h91,0,1), 8'h60, 0, 16'h0, ev(1,0,0,8'h61)});
    v.push_back('{0, 1, mk(2,1,8'h92,1,0), 8'h65, 0, 16'h0, ev(1,0,0,8'h66)});
    v.push_back('{0, 1, mk(2,3,8'h93,0,1), 8'h70, 0, 16'h0, ev(1,1,0,8'h41)});
    v.push_back('{0, 1, mk(2,3,8'h94,0,1), 8'h71, 0, 16'h0, ev(1,0,1,8'h72)});
    foreach (v[i]) begin
      step(v[i].rst, v[i].iv, v[i].ins, v[i].pc, v[i].av, v[i].ar);
      n_total++;
      if (obs !== v[i].exp) $display("FAIL ras[%0d]: got {br,ld,err,pc}=%h want %h", i, obs, v[i].exp);
      else n_pass++;
    end
  endtask
`else
  task automatic test_ras();
    vec_t v[$];
    v.push_back('{0, 1, mk(2,3,8'h77,0,1), 8'h10, 0, 16'h0, ev(1,1,0,8'h77)});
    v.push_back('{0, 1, mk(2,3,8'h78,1,0), 8'h11, 0, 16'h0, ev(1,1,0,8'h78)});
    v.push_back('{0, 1, mk(2,3,8'h79,1,1), 8'h12, 0, 16'h0, ev(1,1,0,8'h79)});
    foreach (v[i]) begin
      step(v[i].rst, v[i].iv, v[i].ins, v[i].pc, v[i].av, v[i].ar);
      n_total++;
      if (obs !== v[i].exp) $display("FAIL ras_disabled[%0d]: got {br,ld,err,pc}=%h want %h", i, obs, v[i].exp);
      else n_pass++;
    end
  endtask
`endif

  task automatic test_reset_mid();
    vec_t v[$];
    logic [10:0] ret_exp;
`ifdef BRANCH_RAS_EN
    ret_exp = ev(1,0,1,8'h0A);
`else
    ret_exp = ev(1,1,0,8'h5D);
`endif
    v.push_back('{0, 1, mk(2,3,8'h5A,1,0), 8'h02, 1, 16'd0, ev(1,1,0,8'h5A)});
    v.push_back('{1, 1, mk(2,3,8'h5B,0,0), 8'h03, 1, 16'd1, ev(0,0,0,8'h00)});
    v.push_back('{0, 1, mk(2,0,8'h5C,0,0), 8'h07, 0, 16'h0, ev(1,0,0,8'h08)});
    v.push_back('{0, 1, mk(2,3,8'h5D,0,1), 8'h09, 0, 16'h0, ret_exp});
    foreach (v[i]) begin
      step(v[i].rst, v[i].iv, v[i].ins, v[i].pc, v[i].av, v[i].ar);
      n_total++;
      if (obs !== v[i].exp) $display("FAIL reset_mid[%0d]: got {br,ld,err,pc}=%h want %h", i, obs, v[i].exp);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit rst, iv, av;
    logic [15:0] ins, ar;
    logic [7:0] pc;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      av  = ($urandom_range(0, 2) == 0);
      ar  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 3));
      ins = 16'($urandom);
      if ($urandom_range(0, 3) != 0) ins[1:0] = 2'b10;
      pc  = 8'($urandom);
      step(rst, iv, ins, pc, av, ar);
      expv = ev(e_br, e_pc_load, e_err, e_new_pc);
      n_total++;
      if (obs !== expv) $display("FAIL random[%0d]: got {br,ld,err,pc}=%h want %h", i, obs, expv);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_cc_update();
    test_forwarding();
    test_wrap_and_nonbranch();
    test_back_to_back();
    test_ras();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
